// File: rtl/lsu_mc.sv
// Multicycle load/store unit: one request per handshake, word-organised SRAM port with
// byte enables, two-beat split for word-straddling accesses, extended load data on response.
module lsu_mc #(
  parameter int XLEN       = 32,
  parameter int AW         = 15,
  parameter bit MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state;

  logic              store_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [OB-1:0]     off_q;
  logic [NB-1:0]     be_hi_q;
  logic [XLEN-1:0]   lo_buf;

  logic [OB-1:0]     req_off;
  logic [2*NB-1:0]   req_mask;
  logic              req_split;
  logic              req_fault;
  logic [AW-1:0]     req_word;
  logic [XLEN-1:0]   req_rot;
  logic [2*XLEN-1:0] rd_pair;
  logic [XLEN-1:0]   load_res;
  logic              unused_addr;

  // 2*NB-bit lane mask; bits above NB belong to the following word
  function automatic logic [2*NB-1:0] lane_mask(input logic [1:0] size, input logic [OB-1:0] off);
    logic [2*NB-1:0] base;
    base = '0;
    for (int i = 0; i < 2*NB; i++)
      if (i < (1 << size)) base[i] = 1'b1;
    return base << off;
  endfunction

  function automatic logic [XLEN-1:0] rotate_store(input logic [XLEN-1:0] d, input logic [OB-1:0] off);
    return XLEN'(({d, d} << {off, 3'b000}) >> XLEN);
  endfunction

  // Align the addressed bytes to bit 0, then sign- or zero-extend from 8<<size bits
  function automatic logic [XLEN-1:0] extend_load(input logic [2*XLEN-1:0] pair, input logic [OB-1:0] off,
                                                  input logic [1:0] size, input logic uns);
    logic        [XLEN-1:0] raw;
    logic signed [XLEN-1:0] sraw;
    int                     sh;
    raw = XLEN'(pair >> {off, 3'b000});
    sh  = XLEN - (8 << size);
    if (sh < 0) sh = 0;
    raw  = raw << sh;
    sraw = $signed(raw) >>> sh;
    return uns ? (raw >> sh) : sraw;
  endfunction

  always_comb begin
    req_off   = req_addr[OB-1:0];
    req_mask  = lane_mask(req_size, req_off);
    req_split = |req_mask[2*NB-1:NB];
    req_fault = (XLEN == 32 && req_size == 2'd3) || (!MISALIGNED && req_split);
    req_word  = req_addr[AW+OB-1:OB];
    req_rot   = rotate_store(req_wdata, req_off);
    rd_pair   = (state == BEAT1) ? {mem_rdata, lo_buf} : {{XLEN{1'b0}}, mem_rdata};
    load_res  = store_q ? '0 : extend_load(rd_pair, off_q, size_q, uns_q);
  end

  assign unused_addr = ^req_addr;

  // Request capture and beat-0 read buffer: data only, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      store_q <= req_store;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      off_q   <= req_off;
      be_hi_q <= req_mask[2*NB-1:NB];
    end
    if (state == BEAT0 && mem_ack) lo_buf <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= req_mask[NB-1:0];
              mem_addr  <= req_word;
              mem_wdata <= req_rot;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ack) begin
            if (state == BEAT0 && be_hi_q != '0) begin
              state    <= BEAT1;
              mem_be   <= be_hi_q;
              mem_addr <= mem_addr + AW'(1);
            end else begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_rdata <= load_res;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
